// File: rtl/action_sampler_pkg.sv
// Shared action encoding for the fighter front end and the player blocks.
// One-hot action codes, their bit positions and the attack priority encoder.
package fight_pkg;

  localparam int BIT_PUNCH = 0;
  localparam int BIT_KICK  = 1;
  localparam int BIT_JUMP  = 2;
  localparam int BIT_WAIT  = 3;
  localparam int BIT_LEFT  = 4;
  localparam int BIT_RIGHT = 5;

  localparam logic [5:0] ACT_IDLE       = 6'b000000;
  localparam logic [5:0] ACT_PUNCH      = 6'b000001;
  localparam logic [5:0] ACT_KICK       = 6'b000010;
  localparam logic [5:0] ACT_JUMP       = 6'b000100;
  localparam logic [5:0] ACT_WAIT       = 6'b001000;
  localparam logic [5:0] ACT_MOVE_LEFT  = 6'b010000;
  localparam logic [5:0] ACT_MOVE_RIGHT = 6'b100000;

  // Buttons whose presses are edge-captured; wait is sampled as a level.
  localparam logic [5:0] EDGE_MASK = 6'b110111;

  function automatic logic [5:0] prio_select(input logic [5:0] pend, input logic wait_lvl);
    logic [5:0] sel;
    if (pend[BIT_PUNCH]) begin
      sel = ACT_PUNCH;
    end else if (pend[BIT_KICK]) begin
      sel = ACT_KICK;
    end else if (pend[BIT_JUMP]) begin
      sel = ACT_JUMP;
    end else if (pend[BIT_LEFT]) begin
      sel = ACT_MOVE_LEFT;
    end else if (pend[BIT_RIGHT]) begin
      sel = ACT_MOVE_RIGHT;
    end else if (wait_lvl) begin
      sel = ACT_WAIT;
    end else begin
      sel = ACT_IDLE;
    end
    return sel;
  endfunction

endpackage

// File: rtl/action_sampler_if.sv
// Button/action bundle between the input conditioner and its environment.
interface action_sampler_if;
  logic [5:0] left_buttons_raw;
  logic [5:0] right_buttons_raw;
  logic [5:0] left_player_input;
  logic [5:0] right_player_input;
  logic       game_tick;

  modport master (
    output left_buttons_raw, right_buttons_raw,
    input  left_player_input, right_player_input, game_tick
  );

  modport slave (
    input  left_buttons_raw, right_buttons_raw,
    output left_player_input, right_player_input, game_tick
  );
endinterface

// File: rtl/action_sampler_debouncer.sv
// One push-button: 2-flop synchroniser, stability counter, debounced level
// and a one-cycle pulse coinciding with the first cycle the level reads 1.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(DEBOUNCE_CYCLES);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc_s;
  logic          level_q, level_d;
  logic          rise_q, rise_d;

  assign cnt_inc_s = cnt_q + CW'(1);

  // Stability counter: level flips only after LIMIT consecutive disagreeing samples.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    if (sync_q[1] == level_q) begin
      cnt_d = '0;
    end else if (cnt_inc_s == LIMIT) begin
      cnt_d   = '0;
      level_d = ~level_q;
      rise_d  = ~level_q;
    end else begin
      cnt_d = cnt_inc_s;
    end
  end

  // Synchroniser and debounce state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b00;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], raw_i};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/action_sampler.sv
// Conditions both players' buttons and presents one coherent action pair per game tick.
// Optional ACTION_COOLDOWN_EN: an attack forces an idle tick on that player's next load.
module action_sampler
  import fight_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TICK_DIV        = 1024
) (
  input logic              clk,
  input logic              rst_n,
  action_sampler_if.slave  bus
);

  localparam int TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] LAST = TW'(TICK_DIV - 1);

  logic [11:0]      raw_s, lvl_s, rise_s;
  logic [TW-1:0]    cnt_q, cnt_d;
  logic             load_s;
  logic             tick_q, tick_d;
  logic [1:0][5:0]  pend_q, pend_d;
  logic [1:0][5:0]  act_q, act_d;
  logic [1:0]       rec_q, rec_d;
  logic [5:0]       sel_s;
  logic             wait_s;

  assign raw_s = {bus.right_buttons_raw, bus.left_buttons_raw};

  for (genvar g = 0; g < 12; g++) begin : g_btn
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
      .clk     (clk),
      .rst_n   (rst_n),
      .raw_i   (raw_s[g]),
      .level_o (lvl_s[g]),
      .rise_o  (rise_s[g])
    );
  end

  assign load_s = (cnt_q == LAST);

  // Tick divider, pending capture and per-player action selection on load.
  always_comb begin
    cnt_d  = load_s ? '0 : cnt_q + TW'(1);
    tick_d = load_s;
    pend_d = pend_q;
    act_d  = act_q;
    rec_d  = rec_q;
    sel_s  = ACT_IDLE;
    wait_s = 1'b0;
    for (int p = 0; p < 2; p++) begin
      // An edge on the load cycle belongs to the next window.
      pend_d[p] = (load_s ? 6'b000000 : pend_q[p]) | (rise_s[p*6 +: 6] & EDGE_MASK);
      wait_s    = |(lvl_s[p*6 +: 6] & ACT_WAIT);
      sel_s     = prio_select(pend_q[p], wait_s);
      if (load_s) begin
`ifdef ACTION_COOLDOWN_EN
        if (rec_q[p]) begin
          act_d[p] = ACT_IDLE;
          rec_d[p] = 1'b0;
        end else begin
          act_d[p] = sel_s;
          rec_d[p] = (sel_s == ACT_PUNCH) || (sel_s == ACT_KICK);
        end
`else
        act_d[p] = sel_s;
        rec_d[p] = 1'b0;
`endif
      end else begin
        act_d[p] = act_q[p];
      end
    end
  end

  // Tick counter, pending masks, registered actions and tick pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
      pend_q <= '0;
      act_q  <= '0;
      rec_q  <= 2'b00;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
      pend_q <= pend_d;
      act_q  <= act_d;
      rec_q  <= rec_d;
    end
  end

  assign bus.left_player_input  = act_q[0];
  assign bus.right_player_input = act_q[1];
  assign bus.game_tick          = tick_q;

endmodule

// File: tb/tb_action_sampler.sv
// Directed bench for action_sampler with a cycle-level behavioural model.
module tb_action_sampler;
  import fight_pkg::*;

  localparam int DEB  = 4;
  localparam int TICK = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  bit   cmp_en = 1'b0;
  int   total = 0;
  int   bad = 0;

  action_sampler_if bus();

  action_sampler #(.DEBOUNCE_CYCLES(DEB), .TICK_DIV(TICK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model: raw samples delayed two cycles, stability runs, event sets.
  bit [11:0] m_s1, m_s2, m_lvl, m_rise;
  int        m_run [12];
  bit [5:0]  m_pend [2];
  bit [5:0]  m_act [2];
  bit        m_rec [2];
  bit        m_tick;
  int        m_cnt;
  int        prio_bits [5] = '{0, 1, 2, 4, 5};

  always @(posedge clk or negedge rst_n) begin
    bit [11:0] raw;
    bit [11:0] nrise;
    bit        load;
    bit [5:0]  pick;
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; m_lvl = '0; m_rise = '0;
      for (int b = 0; b < 12; b++) m_run[b] = 0;
      for (int p = 0; p < 2; p++) begin
        m_pend[p] = '0; m_act[p] = '0; m_rec[p] = 1'b0;
      end
      m_tick = 1'b0; m_cnt = 0;
    end else begin
      raw  = {bus.right_buttons_raw, bus.left_buttons_raw};
      load = (m_cnt == TICK - 1);
      for (int p = 0; p < 2; p++) begin
        if (load) begin
          pick = 6'b000000;
          for (int k = 0; k < 5; k++)
            if (pick == 6'b000000 && m_pend[p][prio_bits[k]]) pick[prio_bits[k]] = 1'b1;
          if (pick == 6'b000000 && m_lvl[p*6 + 3]) pick = 6'b001000;
`ifdef ACTION_COOLDOWN_EN
          if (m_rec[p]) begin
            pick = 6'b000000;
            m_rec[p] = 1'b0;
          end else begin
            m_rec[p] = (pick == 6'b000001) || (pick == 6'b000010);
          end
`endif
          m_act[p] = pick;
          m_pend[p] = 6'b000000;
        end
        for (int i = 0; i < 6; i++)
          if (i != 3 && m_rise[p*6 + i]) m_pend[p][i] = 1'b1;
      end
      m_tick = load;
      m_cnt  = load ? 0 : m_cnt + 1;
      nrise  = '0;
      for (int b = 0; b < 12; b++) begin
        if (m_s2[b] == m_lvl[b]) m_run[b] = 0;
        else begin
          m_run[b]++;
          if (m_run[b] == DEB) begin
            m_lvl[b] = ~m_lvl[b];
            m_run[b] = 0;
            nrise[b] = m_lvl[b];
          end
        end
      end
      m_rise = nrise;
      m_s2 = m_s1;
      m_s1 = raw;
    end
  end

  // Per-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (cmp_en && rst_n) begin
      total++;
      if ({bus.left_player_input, bus.right_player_input, bus.game_tick} !==
          {m_act[0], m_act[1], m_tick}) begin
        bad++;
        $display("FAIL cycle_model t=%0t: got L=%b R=%b tick=%b want L=%b R=%b tick=%b",
                 $time, bus.left_player_input, bus.right_player_input, bus.game_tick,
                 m_act[0], m_act[1], m_tick);
      end
    end
  end

  task automatic check6(input string name, input logic [5:0] act, input logic [5:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic wait_tick(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.game_tick !== 1'b1 && n < 40);
    if (bus.game_tick !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no tick want tick within 40 cycles", name);
    end
  endtask

  task automatic count_to_tick(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.game_tick !== 1'b1 && n < 64);
  endtask

  initial begin
    int n;
    bus.left_buttons_raw  = 6'b000000;
    bus.right_buttons_raw = 6'b000000;
    repeat (3) @(negedge clk);
    check6("reset_left", bus.left_player_input, 6'b000000);
    check6("reset_right", bus.right_player_input, 6'b000000);
    check6("reset_tick", {5'b00000, bus.game_tick}, 6'b000000);

    // First tick arrives TICK_DIV cycles after release, with idle actions.
    rst_n = 1'b1;
    cmp_en = 1'b1;
    count_to_tick(n);
    check_int("first_tick_latency", n, 16);
    check6("first_tick_left", bus.left_player_input, 6'b000000);
    check6("first_tick_right", bus.right_player_input, 6'b000000);

    // Three-cycle glitch never passes the debouncer.
    bus.left_buttons_raw = ACT_PUNCH;
    repeat (3) @(negedge clk);
    bus.left_buttons_raw = 6'b000000;
    wait_tick("glitch");
    check6("glitch_left", bus.left_player_input, 6'b000000);

    // Kick and punch together: punch wins, kick is dropped.
    bus.left_buttons_raw = ACT_PUNCH | ACT_KICK;
    wait_tick("prio");
    check6("prio_punch", bus.left_player_input, 6'b000001);
    wait_tick("drop");
    check6("kick_dropped", bus.left_player_input, 6'b000000);
    repeat (8) @(negedge clk);
    bus.left_buttons_raw = 6'b000000;
    wait_tick("held_release");
    check6("held_no_repeat", bus.left_player_input, 6'b000000);

    // Held wait repeats on every tick.
    bus.right_buttons_raw = ACT_WAIT;
    for (int t = 0; t < 3; t++) begin
      wait_tick("wait_hold");
      check6("wait_right", bus.right_player_input, 6'b001000);
      check6("wait_left_idle", bus.left_player_input, 6'b000000);
    end
    bus.right_buttons_raw = 6'b000000;
    wait_tick("wait_release");
    check6("wait_released", bus.right_player_input, 6'b000000);

    // Jump rise lands on the load cycle: deferred by one tick.
    repeat (9) @(negedge clk);
    bus.right_buttons_raw = ACT_JUMP;
    wait_tick("jump_load");
    check6("jump_on_load_deferred", bus.right_player_input, 6'b000000);
    repeat (8) @(negedge clk);
    bus.right_buttons_raw = 6'b000000;
    wait_tick("jump_next");
    check6("jump_next_tick", bus.right_player_input, 6'b000100);

    // Punch then kick: recovery behaviour depends on the cooldown option.
    bus.left_buttons_raw = ACT_PUNCH;
    repeat (8) @(negedge clk);
    bus.left_buttons_raw = 6'b000000;
    wait_tick("cd_n");
    check6("cd_tick_n", bus.left_player_input, 6'b000001);
    bus.left_buttons_raw = ACT_KICK;
    repeat (8) @(negedge clk);
    bus.left_buttons_raw = 6'b000000;
    wait_tick("cd_n1");
`ifdef ACTION_COOLDOWN_EN
    check6("cd_tick_n1", bus.left_player_input, 6'b000000);
`else
    check6("cd_tick_n1", bus.left_player_input, 6'b000010);
`endif
    wait_tick("cd_n2");
    check6("cd_tick_n2", bus.left_player_input, 6'b000000);

    // Reset mid-tick with a non-idle action held.
    bus.right_buttons_raw = ACT_MOVE_RIGHT;
    wait_tick("pre_reset");
    check6("move_right", bus.right_player_input, 6'b100000);
    bus.right_buttons_raw = 6'b000000;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check6("midreset_right", bus.right_player_input, 6'b000000);
    check6("midreset_tick", {5'b00000, bus.game_tick}, 6'b000000);
    @(negedge clk);
    rst_n = 1'b1;
    count_to_tick(n);
    check_int("reset_tick_latency", n, 16);
    check6("after_reset_right", bus.right_player_input, 6'b000000);

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
